enemy_pool: RTL
===============

ENEMY_POOL -- requirements
Module: enemy_pool

Interface
REQ-001 N_SLOTS, 10, number of enemy slots (1..15).
REQ-002 SPAWN_PERIOD, 60, tick pulses between spawn attempts (>=1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  spawning allowed when high; kills/probes always serviced.
REQ-006 tick  input  1  one-cycle game-tick pulse (frame rate).
REQ-007 clear_all  input  1  pulse; deactivate every slot.
REQ-008 kill_valid  input  1  kill request.
REQ-009 kill_idx  input  4  slot index to kill.
REQ-010 kill_ready  output  1  kill accepted when kill_valid & kill_ready.
REQ-011 probe_valid  input  1  hit-test request.
REQ-012 probe_x, probe_y  input  10 each  probe box top-left.
REQ-013 probe_w, probe_h  input  6 each  probe box size.
REQ-014 hit_valid  output  1  probe result strobe.
REQ-015 hit  output  1  probe overlapped an active enemy.
REQ-016 hit_idx  output  4  lowest overlapping slot index.
REQ-017 rd_idx  input  4  renderer read index.
REQ-018 rd_x, rd_y  output  10 each  slot position (combinational read).
REQ-019 rd_active  output  1  slot active; 0 when rd_idx >= N_SLOTS.
REQ-020 active_count  output  4  number of active slots.
REQ-021 score_inc  output  1  one-cycle pulse per successful kill.
REQ-022 spawn_pulse  output  1  one-cycle pulse per spawn (sound trigger).

Function
REQ-023 Internal 10-bit maximal-length LFSR advances every cycle, never reaches zero.
REQ-024 Tick counter increments on tick; at SPAWN_PERIOD-1 it wraps to 0 and sets spawn_pending.
REQ-025 FSM states IDLE, SPAWN, CLEAR; kill_ready = 1 only in IDLE.
REQ-026 IDLE->SPAWN when spawn_pending & enable & active_count < N_SLOTS & no accepted kill this cycle; spawn_pending held otherwise (kill wins, spawn deferred).
REQ-027 SPAWN (one cycle): lowest-index free slot written, activated, spawn_pulse=1, spawn_pending cleared, return IDLE.
REQ-028 Spawn x = r mod 620 (one conditional subtract of 620), r = LFSR; y = r' mod 460 (up to two conditional subtracts), r' = LFSR rotated right by 5.
REQ-029 spawn_pending with pool full: held; spawns on the first IDLE cycle a slot frees.
REQ-030 Accepted kill of active slot: slot inactive next cycle, score_inc=1 next cycle; kill of inactive slot or kill_idx >= N_SLOTS: no state change, no score_inc.
REQ-031 clear_all from any state -> CLEAR; one slot cleared per cycle, index 0 upward; N_SLOTS cycles then IDLE; spawn_pending and tick counter zeroed on entry; kills not accepted; clear_all during CLEAR restarts at 0.
REQ-032 Probe latency 1 cycle: hit_valid=1 the cycle after probe_valid, every state.
REQ-033 Overlap per slot: active & px < ex+20 & px+pw > ex & py < ey+20 & py+ph > ey, compared at 11-bit width, no wrap.
REQ-034 Probe sees slot state at the probe_valid cycle (a same-cycle kill is not visible).
REQ-035 hit=0 -> hit_idx=0.
REQ-036 active_count updated in the same cycle as the slot change.

Reset
REQ-037 rst: slots inactive, x/y 0, LFSR 10'h280, tick counter 0, spawn_pending 0, state IDLE.
REQ-038 rst: all registered outputs 0 (kill_ready 1 via IDLE); rst mid-CLEAR/SPAWN aborts immediately.

Structure
REQ-039 game_pkg holds SCREEN_W=640, SCREEN_H=480, ENEMY_SIZE=20, spawn bounds 620/460, FSM state encoding.
REQ-040 One sub-module, lfsr10 (seed, advance each cycle, 10-bit value); remaining logic in enemy_pool.

Verification
REQ-041 SPAWN_PERIOD=2, enable=1, 4 ticks -> two spawn_pulses, slots 0 and 1 active, x<620, y<460, active_count=2.
REQ-042 Slot 3 active at (100,100); probe (110,110,5,10) -> next cycle hit=1, hit_idx=3; probe (120,100,5,10) -> hit=0.
REQ-043 kill_idx=3 on active slot -> score_inc one cycle later, rd_active(3)=0; repeat kill -> no score_inc; kill_idx=12 -> ignored.
REQ-044 Pool full, spawn due -> no spawn; kill slot 5 -> next spawn fills slot 5.
REQ-045 Kill and spawn due same cycle -> kill applied, spawn one cycle later.
REQ-046 clear_all with 10 active -> kill_ready=0 for 10 cycles, active_count=0 after; rst mid-CLEAR -> IDLE, LFSR=10'h280.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, enemy pool FSM encoding and spawn-coordinate helpers.
// No ports; imported by lfsr10 and enemy_pool.
package game_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int ENEMY_SIZE  = 20;
  // Largest top-left coordinate that keeps a whole enemy on screen.
  localparam int SPAWN_X_MAX = SCREEN_W - ENEMY_SIZE;  // 620
  localparam int SPAWN_Y_MAX = SCREEN_H - ENEMY_SIZE;  // 460

  localparam logic [9:0] LFSR_SEED = 10'h280;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // 1023 - 620 < 620, so a single subtract is enough.
  function automatic logic [9:0] spawn_x(input logic [9:0] r);
    logic [9:0] v;
    v = r;
    if (v >= 10'(SPAWN_X_MAX)) v = v - 10'(SPAWN_X_MAX);
    return v;
  endfunction

  // Rotating decorrelates y from x; 1023 needs two subtracts of 460.
  function automatic logic [9:0] spawn_y(input logic [9:0] r);
    logic [9:0] v;
    v = {r[4:0], r[9:5]};
    if (v >= 10'(SPAWN_Y_MAX)) v = v - 10'(SPAWN_Y_MAX);
    if (v >= 10'(SPAWN_Y_MAX)) v = v - 10'(SPAWN_Y_MAX);
    return v;
  endfunction

endpackage

// File: rtl/enemy_pool_lfsr10.sv
// lfsr10: 10-bit maximal-length Fibonacci LFSR (x^10 + x^7 + 1).
// Ports: clk, rst (sync, active-high, loads SEED), value (current state).
// Advances every cycle; a non-zero seed never reaches the all-zero lockup state.
module lfsr10
  import game_pkg::*;
#(
  parameter logic [9:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] value
);

  always_ff @(posedge clk) begin
    if (rst) value <= SEED;
    else     value <= {value[8:0], value[9] ^ value[6]};
  end

endmodule

// File: rtl/enemy_pool.sv
// enemy_pool: fixed pool of enemy slots with timed random spawning, kills,
// bulk clear and a one-cycle-latency box hit test.
// Ports:
//   clk, rst            clock, sync active-high reset
//   enable, tick        spawn enable, game-tick pulse
//   clear_all           deactivate every slot (one per cycle)
//   kill_*              kill request / handshake
//   probe_*, hit*       hit-test request and registered result
//   rd_*                combinational slot read for the renderer
//   active_count        live slot count
//   score_inc           pulse per successful kill
//   spawn_pulse         pulse per spawn
//
// state    | meaning
// ST_IDLE  | waiting; kills accepted, spawn launched when due
// ST_SPAWN | write lowest free slot from the LFSR, one cycle
// ST_CLEAR | deactivate slot clr_idx, walking 0..N_SLOTS-1
module enemy_pool
  import game_pkg::*;
#(
  parameter int N_SLOTS      = 10,
  parameter int SPAWN_PERIOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tick,
  input  logic       clear_all,
  input  logic       kill_valid,
  input  logic [3:0] kill_idx,
  output logic       kill_ready,
  input  logic       probe_valid,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  input  logic [5:0] probe_w,
  input  logic [5:0] probe_h,
  output logic       hit_valid,
  output logic       hit,
  output logic [3:0] hit_idx,
  input  logic [3:0] rd_idx,
  output logic [9:0] rd_x,
  output logic [9:0] rd_y,
  output logic       rd_active,
  output logic [3:0] active_count,
  output logic       score_inc,
  output logic       spawn_pulse
);

  localparam int TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  state_t state, state_nxt;

  logic [N_SLOTS-1:0] active;
  logic [9:0]         pos_x [N_SLOTS];
  logic [9:0]         pos_y [N_SLOTS];
  logic [TW-1:0]      tick_cnt;
  logic               spawn_pending;
  logic [3:0]         clr_idx;
  logic [9:0]         rnd;

  logic               kill_acc;
  logic               kill_hit;
  logic               tick_wrap;
  logic               free_found;
  logic [3:0]         free_idx;
  logic [N_SLOTS-1:0] overlap;
  logic               probe_hit;
  logic [3:0]         probe_idx;

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (rnd)
  );

  assign kill_ready  = (state == ST_IDLE);
  assign spawn_pulse = (state == ST_SPAWN);
  assign kill_acc    = kill_valid & kill_ready;
  assign tick_wrap   = tick && (tick_cnt == TW'(SPAWN_PERIOD - 1));

  // Box overlap at 11 bits so px+pw and ex+20 cannot wrap.
  always_comb begin
    overlap = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      overlap[i] = active[i]
        && ({1'b0, probe_x} < {1'b0, pos_x[i]} + 11'(ENEMY_SIZE))
        && ({1'b0, probe_x} + {5'b0, probe_w} > {1'b0, pos_x[i]})
        && ({1'b0, probe_y} < {1'b0, pos_y[i]} + 11'(ENEMY_SIZE))
        && ({1'b0, probe_y} + {5'b0, probe_h} > {1'b0, pos_y[i]});
    end
  end

  // Descending scans so the lowest matching index is the last one written.
  always_comb begin
    probe_hit    = 1'b0;
    probe_idx    = 4'd0;
    free_found   = 1'b0;
    free_idx     = 4'd0;
    kill_hit     = 1'b0;
    active_count = 4'd0;
    rd_x         = 10'd0;
    rd_y         = 10'd0;
    rd_active    = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (overlap[i]) begin
        probe_hit = 1'b1;
        probe_idx = 4'(i);
      end
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
      if ((kill_idx == 4'(i)) && active[i]) kill_hit = 1'b1;
      if (rd_idx == 4'(i)) begin
        rd_x      = pos_x[i];
        rd_y      = pos_y[i];
        rd_active = active[i];
      end
      active_count = active_count + 4'(active[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // An accepted kill takes priority; the spawn stays pending.
        if (spawn_pending && enable && (active_count < 4'(N_SLOTS)) && !kill_acc)
          state_nxt = ST_SPAWN;
      end
      ST_SPAWN: state_nxt = ST_IDLE;
      ST_CLEAR: begin
        if (clr_idx == 4'(N_SLOTS - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear_all) state_nxt = ST_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active        <= '0;
      tick_cnt      <= '0;
      spawn_pending <= 1'b0;
      clr_idx       <= 4'd0;
      hit_valid     <= 1'b0;
      hit           <= 1'b0;
      hit_idx       <= 4'd0;
      score_inc     <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        pos_x[i] <= 10'd0;
        pos_y[i] <= 10'd0;
      end
    end else begin
      score_inc <= 1'b0;
      hit_valid <= probe_valid;
      if (probe_valid) begin
        hit     <= probe_hit;
        hit_idx <= probe_idx;
      end

      if (clear_all) begin
        tick_cnt      <= '0;
        spawn_pending <= 1'b0;
        clr_idx       <= 4'd0;
      end else begin
        if (tick) tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
        // A fresh wrap in the spawn cycle re-arms the next spawn.
        if (tick_wrap)               spawn_pending <= 1'b1;
        else if (state == ST_SPAWN)  spawn_pending <= 1'b0;

        case (state)
          ST_IDLE: begin
            if (kill_acc && kill_hit) begin
              score_inc <= 1'b1;
              for (int i = 0; i < N_SLOTS; i++)
                if (kill_idx == 4'(i)) active[i] <= 1'b0;
            end
          end
          ST_SPAWN: begin
            if (free_found) begin
              for (int i = 0; i < N_SLOTS; i++) begin
                if (free_idx == 4'(i)) begin
                  active[i] <= 1'b1;
                  pos_x[i]  <= spawn_x(rnd);
                  pos_y[i]  <= spawn_y(rnd);
                end
              end
            end
          end
          ST_CLEAR: begin
            for (int i = 0; i < N_SLOTS; i++)
              if (clr_idx == 4'(i)) active[i] <= 1'b0;
            clr_idx <= clr_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
